// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin arbiter and its response router.
package arb_pkg;
  localparam int ARB_NUM_REQ = 4;
  localparam int ENC_MAX     = 32;

  typedef logic [$clog2(ARB_NUM_REQ)-1:0] req_idx_t;

  function automatic logic onehot_check(input logic [ENC_MAX-1:0] vec);
    return (vec != '0) && ((vec & (vec - ENC_MAX'(1))) == '0);
  endfunction

  // Shared encoder: a vector with several bits set resolves to its lowest set index.
  function automatic int unsigned onehot_to_bin(input logic [ENC_MAX-1:0] vec);
    int unsigned idx;
    idx = 0;
    for (int i = ENC_MAX - 1; i >= 0; i--) begin
      if (vec[i]) idx = i;
    end
    return idx;
  endfunction
endpackage

// File: rtl/rsp_tag_fifo.sv
// In-order tag FIFO holding the requester index of every outstanding transaction.
module rsp_tag_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 8
) (
  input  logic                       clk_i,
  input  logic                       arst_i,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_en;
  logic             pop_en;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push_en = push && !full;
  assign pop_en  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop_en)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_en, pop_en})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: pointers and count define which entries are live.
  always_ff @(posedge clk_i) begin
    if (push_en) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/rr_response_router.sv
// Steers the shared response stream back to the owner of the oldest grant.
// Optional sticky protocol-error flag err_o is built when RSP_ROUTER_ERR_CHECK_EN is defined.
module rr_response_router
  import arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 64,
  parameter int MAX_OUTST  = 8
) (
  input  logic                         clk_i,
  input  logic                         arst_i,
  input  logic [NUM_REQ-1:0]           gnt_i,
  output logic                         allow_o,
  input  logic                         rsp_valid_i,
  input  logic [DATA_WIDTH-1:0]        rsp_data_i,
  output logic                         rsp_ready_o,
  output logic [NUM_REQ-1:0]           rsp_valid_o,
  output logic [DATA_WIDTH-1:0]        rsp_data_o,
  input  logic [NUM_REQ-1:0]           rsp_ready_i,
`ifdef RSP_ROUTER_ERR_CHECK_EN
  output logic                         err_o,
`endif
  output logic [$clog2(MAX_OUTST):0]   outst_cnt_o
);
  localparam int IDX_W = $clog2(NUM_REQ);

  logic [ENC_MAX-1:0] gnt_ext;
  logic [IDX_W-1:0]   push_idx;
  logic [IDX_W-1:0]   head;
  logic               full;
  logic               empty;
  logic               pop;

  assign gnt_ext  = ENC_MAX'(gnt_i);
  assign push_idx = IDX_W'(onehot_to_bin(gnt_ext));
  assign pop      = rsp_valid_i && rsp_ready_o;

  rsp_tag_fifo #(
    .WIDTH(IDX_W),
    .DEPTH(MAX_OUTST)
  ) u_tag_fifo (
    .clk_i     (clk_i),
    .arst_i    (arst_i),
    .push      (gnt_i != '0),
    .push_data (push_idx),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (outst_cnt_o)
  );

  assign allow_o     = !full;
  assign rsp_ready_o = !empty && rsp_ready_i[head];
  assign rsp_data_o  = rsp_data_i;

  always_comb begin
    rsp_valid_o = '0;
    if (rsp_valid_i && !empty) rsp_valid_o[head] = 1'b1;
  end

`ifdef RSP_ROUTER_ERR_CHECK_EN
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      err_o <= 1'b0;
    end else if (((gnt_i != '0) && !onehot_check(gnt_ext)) ||
                 (rsp_valid_i && empty) ||
                 ((gnt_i != '0) && full)) begin
      err_o <= 1'b1;
    end
  end
`endif
endmodule
